// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: loads two operand words (A then B) for an external FPU, holds them
// stable for HOLD_CYCLES cycles, then captures the FPU result and status and offers them
// on a valid/ready output. Keeps saturating overflow/underflow counters and a wrapping
// count of delivered results.
//
// Ports:
//   clock_100Khz   sole clock, rising edge
//   reset          synchronous active-high reset
//   in_valid/in_ready/in_data      operand input handshake (first word A, second B)
//   op_a_out/op_b_out              registered operands driven to the FPU
//   fpu_data_in/fpu_status_in      FPU result and status (0=OVF 1=UNF 2=EXACT 3=INEXACT)
//   res_valid/res_ready/res_data/res_status   captured result handshake
//   ovf_cnt/unf_cnt                saturating 8-bit overflow/underflow result counters
//   op_cnt                         wrapping 16-bit count of completed result handshakes
module fpu_op_sequencer #(
    parameter int unsigned HOLD_CYCLES = 64  // legal range 2..255
) (
    input  logic        clock_100Khz,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [31:0] op_a_out,
    output logic [31:0] op_b_out,
    input  logic [31:0] fpu_data_in,
    input  logic [3:0]  fpu_status_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [3:0]  res_status,
    output logic [7:0]  ovf_cnt,
    output logic [7:0]  unf_cnt,
    output logic [15:0] op_cnt
);

    typedef enum logic [1:0] {StLoadA, StLoadB, StWait, StOutput} state_e;

    localparam logic [7:0] HoldLast   = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0] StatusOvf  = 4'd0;
    localparam logic [3:0] StatusUnf  = 4'd1;
    localparam logic [3:0] StatusExact = 4'd2;

    state_e     state_q, state_d;
    logic [7:0] hold_q;

    logic accept_a;
    logic accept_b;
    logic capture;
    logic res_hs;

    // Qualified events shared by the FSM and the datapath.
    always_comb begin
        accept_a = (state_q == StLoadA) && in_valid && in_ready;
        accept_b = (state_q == StLoadB) && in_valid && in_ready;
        capture  = (state_q == StWait) && (hold_q == HoldLast);
        res_hs   = (state_q == StOutput) && res_ready;
    end

    // State register.
    always_ff @(posedge clock_100Khz) begin
        if (reset) begin
            state_q <= StLoadA;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoadA:  if (accept_a) state_d = StLoadB;
            StLoadB:  if (accept_b) state_d = StWait;
            StWait:   if (capture)  state_d = StOutput;
            StOutput: if (res_hs)   state_d = StLoadA;
            default:  state_d = StLoadA;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready = (state_q == StLoadA) || (state_q == StLoadB);
    end

    // Operand, hold counter, result and statistics registers.
    always_ff @(posedge clock_100Khz) begin
        if (reset) begin
            hold_q     <= 8'd0;
            op_a_out   <= 32'd0;
            op_b_out   <= 32'd0;
            res_valid  <= 1'b0;
            res_data   <= 32'd0;
            res_status <= StatusExact;
            ovf_cnt    <= 8'd0;
            unf_cnt    <= 8'd0;
            op_cnt     <= 16'd0;
        end else begin
            if (accept_a) begin
                op_a_out <= in_data;
            end
            if (accept_b) begin
                op_b_out <= in_data;
                hold_q   <= 8'd0;
            end else if (state_q == StWait) begin
                hold_q <= hold_q + 8'd1;
            end
            if (capture) begin
                res_data   <= fpu_data_in;
                res_status <= fpu_status_in;
                res_valid  <= 1'b1;
                // Codes above 3 are passed through but counted nowhere.
                if (fpu_status_in == StatusOvf && ovf_cnt != 8'hFF) begin
                    ovf_cnt <= ovf_cnt + 8'd1;
                end
                if (fpu_status_in == StatusUnf && unf_cnt != 8'hFF) begin
                    unf_cnt <= unf_cnt + 8'd1;
                end
            end
            if (res_hs) begin
                res_valid <= 1'b0;
                op_cnt    <= op_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboard bench for fpu_op_sequencer. The driver issues operations and pushes the
// expected captured result; a negedge monitor pops and compares when res_valid rises and
// checks operand/counter/retention behaviour every cycle against driver-held expectations.
module tb_fpu_op_sequencer;

    localparam int HOLD  = 64;
    localparam int HOLD2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main DUT (HOLD = 64).
    logic        reset, in_valid, in_ready, res_valid, res_ready;
    logic [31:0] in_data, op_a_out, op_b_out, fpu_data_in, res_data;
    logic [3:0]  fpu_status_in, res_status;
    logic [7:0]  ovf_cnt, unf_cnt;
    logic [15:0] op_cnt;

    // Second DUT (HOLD = 2) for counter saturation.
    logic        reset2, in_valid2, in_ready2, res_valid2, res_ready2;
    logic [31:0] in_data2, op_a2, op_b2, res_data2;
    logic [3:0]  res_status2;
    logic [7:0]  ovf_cnt2, unf_cnt2;
    logic [15:0] op_cnt2;

    fpu_op_sequencer #(.HOLD_CYCLES(HOLD)) dut (
        .clock_100Khz (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .op_a_out     (op_a_out),
        .op_b_out     (op_b_out),
        .fpu_data_in  (fpu_data_in),
        .fpu_status_in(fpu_status_in),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_status   (res_status),
        .ovf_cnt      (ovf_cnt),
        .unf_cnt      (unf_cnt),
        .op_cnt       (op_cnt)
    );

    fpu_op_sequencer #(.HOLD_CYCLES(HOLD2)) dut2 (
        .clock_100Khz (clk),
        .reset        (reset2),
        .in_valid     (in_valid2),
        .in_ready     (in_ready2),
        .in_data      (in_data2),
        .op_a_out     (op_a2),
        .op_b_out     (op_b2),
        .fpu_data_in  (32'h3F80_0000),
        .fpu_status_in(4'd0),
        .res_valid    (res_valid2),
        .res_ready    (res_ready2),
        .res_data     (res_data2),
        .res_status   (res_status2),
        .ovf_cnt      (ovf_cnt2),
        .unf_cnt      (unf_cnt2),
        .op_cnt       (op_cnt2)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  status;
        int          acc;   // cycle count just after the B-accept edge
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // Reference state owned by the driver.
    logic [31:0] exp_a   = 32'd0;
    logic [31:0] exp_b   = 32'd0;
    logic [15:0] exp_op  = 16'd0;
    bit          sat_chk = 1'b0;
    bit          end_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    initial begin
        bit          prev_reset = 1'b0;
        bit          prev_v     = 1'b0;
        bit          prev_r     = 1'b0;
        bit          mon_on     = 1'b0;
        int          m_ovf      = 0;
        int          m_unf      = 0;
        logic [31:0] last_data  = 32'd0;
        logic [3:0]  last_stat  = 4'd2;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (prev_reset) begin
                mon_on    = 1'b1;
                m_ovf     = 0;
                m_unf     = 0;
                last_data = 32'd0;
                last_stat = 4'd2;
                check("rst_res_valid", 32'(res_valid), 32'd0);
                check("rst_in_ready", 32'(in_ready), 32'd1);
                check("rst_res_status", 32'(res_status), 32'd2);
                prev_v = 1'b0;
                prev_r = 1'b0;
            end else if (mon_on) begin
                if (res_valid && !prev_v) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_res_valid: got 1, expected 0 (cycle %0d)", cyc);
                    end else begin
                        e = sb_q.pop_front();
                        check("res_data", res_data, e.data);
                        check("res_status", 32'(res_status), 32'(e.status));
                        check("latency", 32'(cyc - e.acc), 32'(HOLD));
                        if (e.status == 4'd0 && m_ovf < 255) m_ovf++;
                        if (e.status == 4'd1 && m_unf < 255) m_unf++;
                        last_data = e.data;
                        last_stat = e.status;
                    end
                end else if (!res_valid && sb_q.size() > 0 && (cyc - sb_q[0].acc) > HOLD) begin
                    checks++;
                    errors++;
                    $display("FAIL result_timeout: got no res_valid, expected it %0d edges after B",
                             HOLD);
                    void'(sb_q.pop_front());
                end
                if (prev_v && prev_r) begin
                    check("hs_res_valid_clear", 32'(res_valid), 32'd0);
                    check("hs_back_to_load_a", 32'(in_ready), 32'd1);
                end
                if (res_valid || sb_q.size() > 0)
                    check("in_ready_busy", 32'(in_ready), 32'd0);
            end
            if (mon_on) begin
                check("op_a_out", op_a_out, exp_a);
                check("op_b_out", op_b_out, exp_b);
                check("op_cnt", 32'(op_cnt), 32'(exp_op));
                check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
                check("unf_cnt", 32'(unf_cnt), 32'(m_unf));
                check("res_data_held", res_data, last_data);
                check("res_status_held", 32'(res_status), 32'(last_stat));
            end
            if (sat_chk) begin
                check("sat_ovf_cnt", 32'(ovf_cnt2), 32'd255);
                check("sat_unf_cnt", 32'(unf_cnt2), 32'd0);
                check("sat_op_cnt", 32'(op_cnt2), 32'd300);
            end
            if (end_chk) check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
            prev_reset = reset;
            prev_v     = res_valid;
            prev_r     = res_ready;
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] f,
                         input logic [3:0] st, input int gap, input int rr_delay,
                         input bit abort);
        exp_t e;
        bit   got;
        in_valid = 1'b1;
        in_data  = a;
        @(posedge clk); #1;
        exp_a = a;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            @(posedge clk); #1;
        end
        in_valid      = 1'b1;
        in_data       = b;
        fpu_data_in   = f;
        fpu_status_in = st;
        @(posedge clk); #1;
        exp_b    = b;
        in_valid = 1'b0;
        in_data  = $urandom;
        if (abort) begin
            // Hold count reaches 30, then reset lands on the next edge.
            repeat (30) begin
                res_ready = 1'($urandom);
                @(posedge clk); #1;
            end
            res_ready = 1'b1;
            reset     = 1'b1;
            @(posedge clk); #1;
            reset     = 1'b0;
            res_ready = 1'b0;
            exp_a     = 32'd0;
            exp_b     = 32'd0;
            exp_op    = 16'd0;
            repeat (HOLD + 8) @(posedge clk);
            #1;
            return;
        end
        e.data   = f;
        e.status = st;
        e.acc    = cyc;
        sb_q.push_back(e);
        got = 1'b0;
        for (int k = 0; k < HOLD + 4; k++) begin
            if (res_valid) begin
                got = 1'b1;
                break;
            end
            res_ready = 1'($urandom);  // ignored while no result is pending
            @(posedge clk); #1;
        end
        res_ready = 1'b0;
        if (got) begin
            repeat (rr_delay) begin
                fpu_data_in   = $urandom;
                fpu_status_in = 4'($urandom);
                @(posedge clk); #1;
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            exp_op    = exp_op + 16'd1;
            res_ready = 1'b0;
        end
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_data       = 32'd0;
        res_ready     = 1'b0;
        fpu_data_in   = 32'd0;
        fpu_status_in = 4'd2;
        reset2        = 1'b1;
        in_valid2     = 1'b0;
        in_data2      = 32'd0;
        res_ready2    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        reset2 = 1'b0;
        @(posedge clk); #1;

        do_op(32'h1234_5678, 32'h9ABC_DEF0, 32'hCAFE_F00D, 4'd2, 0, 10, 1'b0);
        do_op($urandom, $urandom, $urandom, 4'd3, 5, 2, 1'b0);
        do_op($urandom, $urandom, $urandom, 4'd0, 1, 0, 1'b1);
        do_op($urandom, $urandom, $urandom, 4'd1, 0, 1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            do_op($urandom, $urandom, $urandom, 4'($urandom_range(0, 6)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b0);
        end

        for (int i = 0; i < 300; i++) begin
            in_valid2 = 1'b1;
            in_data2  = $urandom;
            @(posedge clk); #1;
            in_data2  = $urandom;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            for (int k = 0; k < 8 && !res_valid2; k++) begin
                @(posedge clk); #1;
            end
            res_ready2 = 1'b1;
            @(posedge clk); #1;
            res_ready2 = 1'b0;
        end
        sat_chk = 1'b1;
        @(posedge clk); #1;
        sat_chk = 1'b0;
        end_chk = 1'b1;
        @(posedge clk); #1;
        end_chk = 1'b0;
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
